// File: rtl/izh_param_serializer.sv
// izh_param_serializer: shifts four 12-bit Izhikevich parameters MSB-first to a serial loader.
// Define IZH_SER_CHECKSUM_EN to append an XOR checksum byte (56-bit frame instead of 48).
module izh_param_serializer (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic [11:0] param_a,
  input  logic [11:0] param_b,
  input  logic [11:0] param_c,
  input  logic [11:0] param_d,
  output logic        serial_data,
  output logic        load_mode,
  output logic        busy,
  output logic        done
);
`ifdef IZH_SER_CHECKSUM_EN
  localparam int W = 56;
`else
  localparam int W = 48;
`endif
  localparam logic [5:0] LAST = 6'(W - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] sr, sr_n, frame;
  logic [47:0] data;
  logic [5:0] cnt, cnt_n;
  logic sd_n, lm_n, busy_n, done_n;
  assign data = {param_a, param_b, param_c, param_d};
`ifdef IZH_SER_CHECKSUM_EN
  assign frame = {data, data[47:40] ^ data[39:32] ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0]};
`else
  assign frame = data;
`endif
  always_comb begin
    state_n = state;
    sr_n = sr;
    cnt_n = cnt;
    sd_n = serial_data;
    lm_n = load_mode;
    busy_n = busy;
    done_n = 1'b0;
    case (state)
      IDLE: if (start && enable) begin
        state_n = SHIFT;
        sr_n = frame;
        cnt_n = '0;
        sd_n = frame[W-1];
        lm_n = 1'b1;
        busy_n = 1'b1;
      end
      SHIFT: if (enable) begin
        if (cnt == LAST) begin
          state_n = DONE;
          sr_n = '0;
          sd_n = 1'b0;
          lm_n = 1'b0;
          busy_n = 1'b0;
          done_n = 1'b1;
        end else begin
          sr_n = sr << 1;
          cnt_n = cnt + 6'd1;
          sd_n = sr[W-2];
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      serial_data <= 1'b0;
      load_mode <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      sr <= sr_n;
      cnt <= cnt_n;
      serial_data <= sd_n;
      load_mode <= lm_n;
      busy <= busy_n;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_izh_param_serializer.sv
// tb_izh_param_serializer: queue-based reference model plus directed and random frames.
module tb_izh_param_serializer;
`ifdef IZH_SER_CHECKSUM_EN
  localparam int FW = 56;
`else
  localparam int FW = 48;
`endif
  logic clk = 0, reset = 0, enable = 0, start = 0;
  logic [11:0] pa = 0, pb = 0, pc = 0, pd = 0;
  logic serial_data, load_mode, busy, done;
  int errors = 0, checks = 0, done_cnt = 0;
  bit exp_q[$];
  bit mon_q[$];
  bit m_done = 0;

  izh_param_serializer dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .param_a(pa), .param_b(pb), .param_c(pc), .param_d(pd),
    .serial_data(serial_data), .load_mode(load_mode), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void load_frame(logic [47:0] d);
    logic [7:0] x;
    x = '0;
    exp_q.delete();
    for (int i = 47; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef IZH_SER_CHECKSUM_EN
    for (int k = 0; k < 6; k++) x ^= d[k*8 +: 8];
    for (int i = 7; i >= 0; i--) exp_q.push_back(x[i]);
`endif
  endfunction

  // Reference: a frame is a queue of pending bits; the head is what the line must show.
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      exp_q.delete();
      m_done = 0;
    end else if (m_done) m_done = 0;
    else if (exp_q.size() > 0) begin
      if (enable) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) m_done = 1;
      end
    end else if (start && enable) load_frame({pa, pb, pc, pd});
  end

  initial forever begin
    @(negedge clk);
    check("load_mode", load_mode, exp_q.size() > 0);
    check("serial_data", serial_data, exp_q.size() > 0 ? exp_q[0] : 1'b0);
    check("busy", busy, exp_q.size() > 0);
    check("done", done, m_done);
    if (load_mode) mon_q.push_back(serial_data);
    if (done) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(int lim);
    int n = 0;
    while (!done && n < lim) begin
      step();
      n++;
    end
    check("done_timeout", done, 1'b1);
  endtask

  function automatic logic [47:0] mon_head(int stride);
    logic [47:0] g = '0;
    for (int i = 0; i < 48; i++) if (i * stride < mon_q.size()) g[47-i] = mon_q[i*stride];
    return g;
  endfunction

  task automatic set_ref();
    pa = 12'h123; pb = 12'hFEC; pc = 12'hBF0; pd = 12'h008;
  endtask

  task automatic accept();
    mon_q.delete();
    enable = 1;
    start = 1;
    step();
    start = 0;
  endtask

  initial begin
    int d0, bad;
    repeat (3) step();
    check("rst_load_mode", load_mode, 0);
    check("rst_serial", serial_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1;
    set_ref();
    // plain frame at full rate
    d0 = done_cnt;
    accept();
    check("accept_load_mode", load_mode, 1);
    check("accept_busy", busy, 1);
    wait_done(200);
    step();
    check("frame_len", mon_q.size(), FW);
    check("frame_bits", mon_head(1), 48'h123FECBF0008);
    check("done_pulses", done_cnt - d0, 1);
    step();
    // enable alternating: every bit held two cycles
    d0 = done_cnt;
    accept();
    for (int k = 1; k < 400 && !done; k++) begin
      enable = (k % 2 == 0);
      step();
    end
    check("toggle_done", done, 1);
    enable = 1;
    step();
    step();
    check("toggle_len", mon_q.size(), 2 * FW);
    check("toggle_bits", mon_head(2), 48'h123FECBF0008);
    bad = 0;
    for (int i = 0; i + 1 < mon_q.size(); i += 2) if (mon_q[i] != mon_q[i+1]) bad++;
    check("toggle_pairs", bad, 0);
    // new params and start mid-frame are ignored
    d0 = done_cnt;
    accept();
    repeat (20) step();
    pa = 12'hABC; pb = 12'h555; pc = 12'h0F0; pd = 12'hFFF;
    start = 1;
    step();
    start = 0;
    check("midframe_busy", busy, 1);
    wait_done(200);
    step();
    check("midframe_bits", mon_head(1), 48'h123FECBF0008);
    repeat (10) step();
    check("midframe_no_second", done_cnt - d0, 1);
    check("midframe_idle", load_mode, 0);
    // reset abort at bit 30
    set_ref();
    d0 = done_cnt;
    accept();
    repeat (30) step();
    reset = 0;
    #1;
    check("abort_load_mode", load_mode, 0);
    check("abort_serial", serial_data, 0);
    check("abort_busy", busy, 0);
    step();
    reset = 1;
    check("abort_no_done", done_cnt - d0, 0);
    accept();
    wait_done(200);
    step();
    check("after_abort_len", mon_q.size(), FW);
    check("after_abort_bits", mon_head(1), 48'h123FECBF0008);
    // start with enable low in IDLE is not queued
    enable = 0;
    start = 1;
    repeat (3) step();
    start = 0;
    enable = 1;
    step();
    check("ignored_start", busy, 0);
    // back-to-back with start held; model enforces the two-cycle gap
    start = 1;
    repeat (3 * FW + 20) step();
    start = 0;
    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      enable = $urandom_range(0, 3) != 0;
      start = $urandom_range(0, 7) == 0;
      if ($urandom_range(0, 3) == 0) begin
        pa = 12'($urandom); pb = 12'($urandom); pc = 12'($urandom); pd = 12'($urandom);
      end
      reset = $urandom_range(0, 399) != 0;
      step();
    end
    reset = 1;
    start = 0;
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
